contador_modos: RTL and testbench

Synchronous N-bit counter with selectable up, down, load and hold modes, programmable upper limit, and a choice of wrap-around or saturation. It replaces the fixed 3-bit T-flip-flop counter as the general counting block for the design. Intended consumers are display drivers, timers and sequencers that need a bounded count with a terminal-count pulse.

---
 rtl/contador_pkg.sv | 9 +
 rtl/contador_prox.sv | 46 ++++
 rtl/contador_modos.sv | 48 ++++
 tb/tb_contador_modos.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// contador_pkg: shared mode and direction constants for the contador_modos counter
package contador_pkg;
    localparam logic [1:0] MODO_SOBE    = 2'b00;
    localparam logic [1:0] MODO_DESCE   = 2'b01;
    localparam logic [1:0] MODO_CARREGA = 2'b10;
    localparam logic [1:0] MODO_PARA    = 2'b11;
    localparam logic DIR_SOBE  = 1'b0;
    localparam logic DIR_DESCE = 1'b1;
endpackage

// File: rtl/contador_prox.sv
// contador_prox: combinational next-state logic (count, terminal pulse, direction)
// Ports: contador/direcao = current state; chaves = mode; limite = max count;
//        load_valor = load value; prox/fim/direcao_prox = next state.
module contador_prox
    import contador_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int SATURA = 0
) (
    input  logic [WIDTH-1:0] contador,
    input  logic             direcao,
    input  logic [1:0]       chaves,
    input  logic [WIDTH-1:0] limite,
    input  logic [WIDTH-1:0] load_valor,
    output logic [WIDTH-1:0] prox,
    output logic             fim,
    output logic             direcao_prox
);
    // Boundaries are tested before stepping, so +1/-1 never overflow WIDTH bits.
    always_comb begin
        prox         = contador;
        fim          = 1'b0;
        direcao_prox = direcao;
        case (chaves)
            MODO_SOBE: begin
                direcao_prox = DIR_SOBE;
                if (contador < limite) prox = contador + WIDTH'(1);
                else begin
                    prox = (SATURA != 0) ? limite : '0;
                    fim  = 1'b1;
                end
            end
            MODO_DESCE: begin
                direcao_prox = DIR_DESCE;
                if (contador > limite) prox = limite;
                else if (contador != '0) prox = contador - WIDTH'(1);
                else begin
                    prox = (SATURA != 0) ? '0 : limite;
                    fim  = 1'b1;
                end
            end
            MODO_CARREGA: prox = (load_valor > limite) ? limite : load_valor;
            default: ;
        endcase
    end
endmodule

// File: rtl/contador_modos.sv
// contador_modos: up/down/load/hold counter with programmable limit, wrap or saturate
// Ports: clock, reset (sync, active-high), enable, chaves (mode), load_valor,
//        limite; outputs contador, fim (terminal pulse), direcao (0 up, 1 down).
module contador_modos
    import contador_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int SATURA = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       chaves,
    input  logic [WIDTH-1:0] load_valor,
    input  logic [WIDTH-1:0] limite,
    output logic [WIDTH-1:0] contador,
    output logic             fim,
    output logic             direcao
);
    logic [WIDTH-1:0] prox;
    logic             fim_prox;
    logic             direcao_prox;

    contador_prox #(.WIDTH(WIDTH), .SATURA(SATURA)) u_prox (
        .contador     (contador),
        .direcao      (direcao),
        .chaves       (chaves),
        .limite       (limite),
        .load_valor   (load_valor),
        .prox         (prox),
        .fim          (fim_prox),
        .direcao_prox (direcao_prox)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            contador <= '0;
            fim      <= 1'b0;
            direcao  <= DIR_SOBE;
        end else if (!enable) begin
            fim <= 1'b0;
        end else begin
            contador <= prox;
            fim      <= fim_prox;
            direcao  <= direcao_prox;
        end
    end
endmodule

// File: tb/tb_contador_modos.sv
// tb_contador_modos: randomized and directed checks of three counter variants against a model
module tb_contador_modos;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] chaves = 2'b11;
    logic [3:0] load_valor = '0;
    logic [3:0] limite = '0;

    logic [2:0] cw, cs;
    logic [3:0] c4;
    logic       fw, fs, f4, dw, ds, d4;

    int checks = 0;
    int errors = 0;
    int mw_c, mw_f, mw_d, ms_c, ms_f, ms_d, m4_c, m4_f, m4_d;

    always #5 clock = ~clock;

    contador_modos #(.WIDTH(3), .SATURA(0)) u_wrap (
        .clock(clock), .reset(reset), .enable(enable), .chaves(chaves),
        .load_valor(load_valor[2:0]), .limite(limite[2:0]),
        .contador(cw), .fim(fw), .direcao(dw));
    contador_modos #(.WIDTH(3), .SATURA(1)) u_sat (
        .clock(clock), .reset(reset), .enable(enable), .chaves(chaves),
        .load_valor(load_valor[2:0]), .limite(limite[2:0]),
        .contador(cs), .fim(fs), .direcao(ds));
    contador_modos #(.WIDTH(4), .SATURA(0)) u_w4 (
        .clock(clock), .reset(reset), .enable(enable), .chaves(chaves),
        .load_valor(load_valor), .limite(limite),
        .contador(c4), .fim(f4), .direcao(d4));

    // Behavioural reference: plain integer arithmetic straight from the mode rules.
    task automatic model(input int sat, input int rst, input int en, input int md,
                         input int lv, input int lim, inout int c, inout int f, inout int d);
        if (rst != 0) begin c = 0; f = 0; d = 0; end
        else if (en == 0 || md == 3) f = 0;
        else if (md == 0) begin
            d = 0;
            if (c < lim) begin c = c + 1; f = 0; end
            else begin c = sat ? lim : 0; f = 1; end
        end else if (md == 1) begin
            d = 1;
            if (c > lim) begin c = lim; f = 0; end
            else if (c > 0) begin c = c - 1; f = 0; end
            else begin c = sat ? 0 : lim; f = 1; end
        end else begin
            c = (lv < lim) ? lv : lim;
            f = 0;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] v, input logic [3:0] l);
        reset = r; enable = e; chaves = m; load_valor = v; limite = l;
        @(posedge clock);
        model(0, r, e, m, v & 7, l & 7, mw_c, mw_f, mw_d);
        model(1, r, e, m, v & 7, l & 7, ms_c, ms_f, ms_d);
        model(0, r, e, m, v, l, m4_c, m4_f, m4_d);
        @(negedge clock);
    endtask

    task automatic test_reset;
        step(1, 0, 2'b00, 4'd0, 4'd7);
        checks++;
        if ({cw, fw, dw, cs, fs, ds, c4, f4, d4} !== '0) begin
            errors++;
            $display("FAIL reset: got %0d/%0d/%0d %0d/%0d/%0d %0d/%0d/%0d want all 0",
                     cw, fw, dw, cs, fs, ds, c4, f4, d4);
        end
    endtask

    task automatic test_count_up;
        step(1, 1, 2'b00, 4'd0, 4'd7);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 2'b00, 4'd0, 4'd7);
            checks++;
            if (cw !== 3'((i + 1) % 8) || fw !== (i == 7) || dw !== 1'b0) begin
                errors++;
                $display("FAIL count_up[%0d]: got c=%0d f=%0d d=%0d want c=%0d f=%0d d=0",
                         i, cw, fw, dw, (i + 1) % 8, i == 7);
            end
        end
    endtask

    task automatic test_down_sat;
        step(0, 1, 2'b10, 4'd2, 4'd7);
        checks++;
        if (cs !== 3'd2 || fs !== 1'b0) begin
            errors++;
            $display("FAIL down_sat_load: got c=%0d f=%0d want c=2 f=0", cs, fs);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 2'b01, 4'd0, 4'd7);
            checks++;
            if (cs !== 3'(i < 2 ? 1 - i : 0) || fs !== (i >= 2) || ds !== 1'b1) begin
                errors++;
                $display("FAIL down_sat[%0d]: got c=%0d f=%0d d=%0d want c=%0d f=%0d d=1",
                         i, cs, fs, ds, i < 2 ? 1 - i : 0, i >= 2);
            end
        end
    endtask

    task automatic test_load_clamp;
        step(0, 1, 2'b10, 4'd7, 4'd5);
        checks++;
        if (cw !== 3'd5 || fw !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp: got c=%0d f=%0d want c=5 f=0", cw, fw);
        end
        step(0, 1, 2'b00, 4'd0, 4'd3);
        checks++;
        if (cw !== 3'd0 || fw !== 1'b1 || cs !== 3'd3 || fs !== 1'b1) begin
            errors++;
            $display("FAIL lowered_limit: got wrap c=%0d f=%0d sat c=%0d f=%0d want 0/1 3/1",
                     cw, fw, cs, fs);
        end
    endtask

    task automatic test_hold_enable;
        step(1, 1, 2'b00, 4'd0, 4'd7);
        for (int i = 0; i < 4; i++) step(0, 1, 2'b00, 4'd0, 4'd7);
        for (int i = 0; i < 5; i++) begin
            step(0, i < 3, i < 3 ? 2'b11 : 2'b00, 4'd0, 4'd7);
            checks++;
            if (cw !== 3'd4 || fw !== 1'b0 || dw !== 1'b0) begin
                errors++;
                $display("FAIL hold_enable[%0d]: got c=%0d f=%0d d=%0d want c=4 f=0 d=0",
                         i, cw, fw, dw);
            end
        end
        step(0, 1, 2'b00, 4'd0, 4'd7);
        checks++;
        if (cw !== 3'd5) begin
            errors++;
            $display("FAIL hold_resume: got c=%0d want 5", cw);
        end
    endtask

    task automatic test_mid_reset;
        step(0, 1, 2'b01, 4'd0, 4'd9);
        step(1, 1, 2'b00, 4'd0, 4'd9);
        for (int i = 0; i < 6; i++) step(0, 1, 2'b00, 4'd0, 4'd9);
        checks++;
        if (c4 !== 4'd6) begin
            errors++;
            $display("FAIL mid_reset_pre: got c=%0d want 6", c4);
        end
        step(0, 1, 2'b01, 4'd0, 4'd9);
        step(1, 1, 2'b00, 4'd0, 4'd9);
        checks++;
        if (c4 !== 4'd0 || f4 !== 1'b0 || d4 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got c=%0d f=%0d d=%0d want 0/0/0", c4, f4, d4);
        end
        step(0, 1, 2'b00, 4'd0, 4'd9);
        checks++;
        if (c4 !== 4'd1) begin
            errors++;
            $display("FAIL mid_reset_resume: got c=%0d want 1", c4);
        end
    endtask

    task automatic test_limit_zero;
        step(1, 1, 2'b00, 4'd0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 2'(i % 2), 4'(i), 4'd0);
            checks++;
            if ({cw, cs, c4} !== '0 || {fw, fs, f4} !== 3'b111) begin
                errors++;
                $display("FAIL limit_zero[%0d]: got c=%0d/%0d/%0d f=%0d/%0d/%0d want 0s, fim 1",
                         i, cw, cs, c4, fw, fs, f4);
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 29) == 0, $urandom_range(0, 5) != 0, 2'($urandom),
                 4'($urandom), 4'($urandom));
            checks++;
            if (int'(cw) != mw_c || int'(fw) != mw_f || int'(dw) != mw_d) begin
                errors++;
                $display("FAIL random_wrap[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, cw, fw, dw, mw_c, mw_f, mw_d);
            end
            checks++;
            if (int'(cs) != ms_c || int'(fs) != ms_f || int'(ds) != ms_d) begin
                errors++;
                $display("FAIL random_sat[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, cs, fs, ds, ms_c, ms_f, ms_d);
            end
            checks++;
            if (int'(c4) != m4_c || int'(f4) != m4_f || int'(d4) != m4_d) begin
                errors++;
                $display("FAIL random_w4[%0d]: got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, c4, f4, d4, m4_c, m4_f, m4_d);
            end
        end
    endtask

    initial begin
        {mw_c, mw_f, mw_d, ms_c, ms_f, ms_d, m4_c, m4_f, m4_d} = '0;
        @(negedge clock);
        test_reset;
        test_count_up;
        test_down_sat;
        test_load_clamp;
        test_hold_enable;
        test_mid_reset;
        test_limit_zero;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
